// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - sequential inverse AES-128 key schedule, round 10 down to 0
// The sbox is computed as GF(2^8) inverse (x^254) followed by the AES affine map.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] t;
  logic [7:0] r;

  always_comb begin
    t = a;
    r = 8'h01;
    // r accumulates x^2 * x^4 * ... * x^128 = x^254, the inverse (0 maps to 0)
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    c = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   round;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [7:0]   rcon;
  logic [127:0] key_prev;

  always_comb begin
    w3    = key_reg[31:0]  ^ key_reg[63:32];
    w2    = key_reg[63:32] ^ key_reg[95:64];
    w1    = key_reg[95:64] ^ key_reg[127:96];
    rot_w = {w3[23:0], w3[31:24]};
  end

  sbox u_sbox3 (.a(rot_w[31:24]), .c(sub_w[31:24]));
  sbox u_sbox2 (.a(rot_w[23:16]), .c(sub_w[23:16]));
  sbox u_sbox1 (.a(rot_w[15:8]),  .c(sub_w[15:8]));
  sbox u_sbox0 (.a(rot_w[7:0]),   .c(sub_w[7:0]));

  always_comb begin
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    w0       = key_reg[127:96] ^ sub_w ^ {rcon, 24'h000000};
    key_prev = {w0, w1, w2, w3};
  end

  // key_reg and round are the output registers themselves
  assign rk_out   = key_reg;
  assign rk_round = round;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= '0;
      round    <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg  <= key_in;
            round    <= 4'd10;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (round != 4'd0) begin
              key_reg <= key_prev;
              round   <= round - 4'd1;
            end else begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - directed and randomized checks of the inverse key schedule
// Reference keys come from a table-driven model built by brute-force field inversion.
module tb_aes_inv_key_schedule;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  aes_inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0]   sbox_tbl [256];
  logic [7:0]   rcon_tbl [11];
  logic [127:0] exp_keys [11];
  logic [127:0] got_keys [11];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    int x;
    acc = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x * 2;
      if (x > 255) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      sbox_tbl[x] = s ^ 8'h63;
    end
    rc = 8'h01;
    rcon_tbl[0] = 8'h00;
    for (int r = 1; r <= 10; r++) begin
      rcon_tbl[r] = rc;
      rc = gf_mul(rc, 8'h02);
    end
  endtask

  // Undo one expansion round at a time, working on byte arrays of the four words.
  task automatic gen_ref(input logic [127:0] k10);
    logic [7:0] b [16];
    logic [7:0] p [16];
    exp_keys[10] = k10;
    for (int r = 10; r >= 1; r--) begin
      for (int i = 0; i < 16; i++) b[i] = exp_keys[r][127 - 8 * i -: 8];
      for (int j = 15; j >= 4; j--) p[j] = b[j] ^ b[j - 4];
      for (int j = 0; j < 4; j++) p[j] = b[j] ^ sbox_tbl[p[12 + ((j + 1) % 4)]];
      p[0] = p[0] ^ rcon_tbl[r];
      for (int i = 0; i < 16; i++) exp_keys[r - 1][127 - 8 * i -: 8] = p[i];
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Caller positions at a negedge; start is driven immediately so back-to-back reuse works.
  task automatic run_seq(input logic [127:0] k, input int stall_pct, input bit inject);
    int r;
    int guard;
    int stalls;
    int lat;
    bit rdy;
    bit injected;
    gen_ref(k);
    start = 1'b1;
    key_in = k;
    @(negedge clk);
    start = 1'b0;
    key_in = '0;
    r = 10;
    guard = 0;
    stalls = 0;
    lat = 1;
    injected = 1'b0;
    while (r >= 0 && guard < 300) begin
      rdy = ($urandom_range(99) >= stall_pct);
      rk_ready = rdy;
      chk("valid", {127'b0, rk_valid}, 128'd1);
      chk("busy", {127'b0, busy}, 128'd1);
      chk("round", {124'b0, rk_round}, r[127:0]);
      chk("key", rk_out, exp_keys[r]);
      got_keys[r] = rk_out;
      if (inject && r == 6 && !injected) begin
        start = 1'b1;
        key_in = ~k;
        injected = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
      guard++;
      if (rdy) r--;
      else stalls++;
    end
    chk("seq_timeout", {127'b0, guard >= 300}, 128'd0);
    chk("done", {127'b0, done}, 128'd1);
    chk("busy_at_done", {127'b0, busy}, 128'd0);
    chk("valid_at_done", {127'b0, rk_valid}, 128'd0);
    chk("done_latency", lat[127:0], (12 + stalls));
    rk_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] rk;
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    rk_ready = 1'b0;
    build_tables();
    repeat (2) @(negedge clk);
    chk("rst_valid", {127'b0, rk_valid}, 128'd0);
    chk("rst_out", rk_out, 128'd0);
    chk("rst_round", {124'b0, rk_round}, 128'd0);
    chk("rst_busy_done", {126'b0, busy, done}, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 appendix A, no stalls
    @(negedge clk);
    run_seq(FIPS_K10, 0, 1'b0);
    chk("fips_k10", got_keys[10], FIPS_K10);
    chk("fips_k9", got_keys[9], FIPS_K9);
    chk("fips_k1", got_keys[1], FIPS_K1);
    chk("fips_k0", got_keys[0], FIPS_K0);
    @(negedge clk);
    chk("done_one_cycle", {127'b0, done}, 128'd0);

    // all-zero cipher key
    run_seq(ZERO_K10, 0, 1'b0);
    chk("zero_k1", got_keys[1], ZERO_K1);
    chk("zero_k0", got_keys[0], 128'd0);
    @(negedge clk);

    // backpressure on the FIPS vector
    run_seq(FIPS_K10, 45, 1'b0);
    chk("bp_k9", got_keys[9], FIPS_K9);
    chk("bp_k0", got_keys[0], FIPS_K0);
    @(negedge clk);

    // start with a different key mid-sequence is ignored
    run_seq(FIPS_K10, 20, 1'b1);
    chk("inj_k0", got_keys[0], FIPS_K0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("inj_single_done", {127'b0, done}, 128'd0);
      chk("inj_no_restart", {127'b0, rk_valid}, 128'd0);
    end

    // reset after round 6 has been emitted
    gen_ref(FIPS_K10);
    rk_ready = 1'b1;
    start = 1'b1;
    key_in = FIPS_K10;
    @(negedge clk);
    start = 1'b0;
    for (int r = 10; r >= 6; r--) begin
      chk("pre_rst_key", rk_out, exp_keys[r]);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {127'b0, rk_valid}, 128'd0);
    chk("midrst_out", rk_out, 128'd0);
    chk("midrst_round", {124'b0, rk_round}, 128'd0);
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {127'b0, done}, 128'd0);
    end
    rk_ready = 1'b0;
    rst_n = 1'b1;
    run_seq(FIPS_K10, 0, 1'b0);
    chk("post_rst_k0", got_keys[0], FIPS_K0);

    // back-to-back: start in the done cycle
    run_seq(ZERO_K10, 0, 1'b0);
    chk("b2b_k0", got_keys[0], 128'd0);
    @(negedge clk);

    // random round-10 keys with random stalls
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_seq(rk, 30, 1'b0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
